// File: rtl/demux_frame.sv
// demux_frame: registered 1:N_CH demultiplexer that packs DATA_W-bit beats into one frame
// of N_CH lanes and holds the frame until the consumer takes it.
//
// Ports:
//   clk, rst              single rising-edge clock, synchronous active-high reset
//   inValid/inReady       input beat handshake (inReady is combinational)
//   inData                input beat
//   inSel                 destination lane in addressed mode
//   inMode                0 = addressed, 1 = sequential (latched on the first beat of a frame)
//   outValid/outReady     frame handshake
//   outData               packed frame, lane 0 in the MSBs
//   outLaneMask           bit i set when lane i was written in this frame
//   errSel                one-cycle pulse when an addressed beat named a lane >= N_CH
//
// Optional: define DEMUX_FRAME_TIMEOUT_EN to flush a partial frame after TIMEOUT_CYC idle
// cycles. Without it partial frames wait indefinitely.
module demux_frame #(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned N_CH        = 8,
    parameter int unsigned SEL_W       = $clog2(N_CH),
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [DATA_W-1:0]      inData,
    input  logic [SEL_W-1:0]       inSel,
    input  logic                   inMode,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [N_CH*DATA_W-1:0] outData,
    output logic [N_CH-1:0]        outLaneMask,
    output logic                   errSel
);

    typedef enum logic [0:0] {StFill, StHold} state_e;

    state_e                  state_q, state_d;
    logic [N_CH*DATA_W-1:0]  data_q, data_d;
    logic [N_CH-1:0]         mask_q, mask_d;
    logic [SEL_W-1:0]        ptr_q, ptr_d;
    logic                    mode_q, mode_d;

    logic                    accept;
    logic                    release_frm;
    logic                    empty;
    logic                    mode_eff;
    logic [SEL_W-1:0]        lane;
    logic                    lane_ok;
    logic                    complete;
    logic                    timeout_fire;

    assign inReady     = !rst && ((state_q == StFill) || ((state_q == StHold) && outReady));
    assign outValid    = (state_q == StHold);
    assign outData     = data_q;
    assign outLaneMask = mask_q;

    assign accept      = inValid && inReady;
    assign release_frm = outValid && outReady;
    // A beat arriving together with a release starts a fresh frame, so it may relatch the mode.
    assign empty       = release_frm || (mask_q == '0);
    assign mode_eff    = empty ? inMode : mode_q;
    assign lane        = mode_eff ? ptr_q : inSel;
    assign lane_ok     = 32'(lane) < N_CH;

`ifdef DEMUX_FRAME_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] idle_cnt_q;

    assign timeout_fire = (state_q == StFill) && (mask_q != '0) && !accept &&
                          (idle_cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else if ((state_q != StFill) || (mask_q == '0) || accept || timeout_fire) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign timeout_fire   = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    always_comb begin
        data_d   = release_frm ? '0 : data_q;
        mask_d   = release_frm ? '0 : mask_q;
        ptr_d    = ptr_q;
        mode_d   = mode_q;
        state_d  = release_frm ? StFill : state_q;
        complete = 1'b0;
        if (accept) begin
            if (empty) begin
                mode_d = inMode;
            end
            if (lane_ok) begin
                data_d[(N_CH - 1 - 32'(lane)) * DATA_W +: DATA_W] = inData;
                mask_d[lane] = 1'b1;
                complete     = mode_eff ? (32'(lane) == N_CH - 1) : (&mask_d);
            end
            if (mode_eff) begin
                ptr_d = complete ? '0 : ptr_q + 1'b1;
            end
            if (complete) begin
                state_d = StHold;
            end
        end
        if (timeout_fire) begin
            state_d = StHold;
            ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFill;
            data_q  <= '0;
            mask_q  <= '0;
            ptr_q   <= '0;
            mode_q  <= 1'b0;
            errSel  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            mode_q  <= mode_d;
            errSel  <= accept && !lane_ok;
        end
    end

endmodule
